// File: rtl/step_interval_timer_if.sv
// Bus between the step-maker (master) and the interval timer (slave):
// restart/pace inputs, configuration writes and timer status.
interface step_interval_timer_if #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PRE_W  = 8,
    parameter int unsigned STEP_W = 16
) ();
    logic              T;
    logic              P;
    logic              en;
    logic              period_ld;
    logic [CNT_W-1:0]  period_in;
    logic [PRE_W-1:0]  presc_in;
    logic              Z;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic [STEP_W-1:0] step_cnt;
    logic              ovr;

    modport master (
        output T, P, en, period_ld, period_in, presc_in,
        input  Z, busy, count, step_cnt, ovr
    );

    modport slave (
        input  T, P, en, period_ld, period_in, presc_in,
        output Z, busy, count, step_cnt, ovr
    );
endinterface

// File: rtl/step_interval_timer.sv
// Interval timer paired with the step-maker: restart on T, expiry level Z after
// a prescaled period, overrun detection on unanswered Z, and a P edge counter.
module step_interval_timer #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PRE_W      = 8,
    parameter int unsigned DEF_PERIOD = 1000,
    parameter int unsigned OVR_LIM    = 4,
    parameter int unsigned STEP_W     = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    step_interval_timer_if.slave bus
);
    localparam int unsigned WAIT_W = (OVR_LIM < 2) ? 1 : $clog2(OVR_LIM + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_EXPIRED
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   period_r, period_d;
    logic [PRE_W-1:0]   presc_r, presc_d;
    logic [PRE_W-1:0]   presc_act_q, presc_act_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               ovr_q, ovr_d;
    logic               z_q, busy_q;
    logic               p_q, p_qq;
    logic [STEP_W-1:0]  step_q, step_d;

    logic [CNT_W-1:0]   ld_period_c;
    logic [PRE_W-1:0]   ld_presc_c;
    logic               tick_c;

    // Next-state and datapath decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        period_d    = period_r;
        presc_d     = presc_r;
        presc_act_d = presc_act_q;
        pre_cnt_d   = pre_cnt_q;
        wait_d      = wait_q;
        ovr_d       = ovr_q;
        step_d      = step_q;

        // A config write coinciding with T is used directly by that reload
        ld_period_c = bus.period_ld ? bus.period_in : period_r;
        ld_presc_c  = bus.period_ld ? bus.presc_in  : presc_r;
        tick_c      = bus.en && (pre_cnt_q == presc_act_q);

        if (bus.T) begin
            pre_cnt_d   = '0;
            wait_d      = '0;
            presc_act_d = ld_presc_c;
            if (ld_period_c == '0) begin
                state_d = S_EXPIRED;
                count_d = '0;
            end else begin
                state_d = S_COUNT;
                count_d = ld_period_c;
            end
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (tick_c) begin
                        pre_cnt_d = '0;
                        if (count_q == CNT_W'(1)) begin
                            count_d = '0;
                            wait_d  = '0;
                            state_d = S_EXPIRED;
                        end else begin
                            count_d = count_q - CNT_W'(1);
                        end
                    end else if (bus.en) begin
                        pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end
                end
                S_EXPIRED: begin
                    // Wait counter saturates at the limit so ovr is set only once
                    if (wait_q != WAIT_W'(OVR_LIM)) begin
                        wait_d = wait_q + WAIT_W'(1);
                        if (wait_q == WAIT_W'(OVR_LIM - 1)) begin
                            ovr_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (bus.period_ld) begin
            period_d = bus.period_in;
            presc_d  = bus.presc_in;
            ovr_d    = 1'b0;
        end

        if (p_q && !p_qq && (step_q != '1)) begin
            step_d = step_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= CNT_W'(DEF_PERIOD);
            period_r    <= CNT_W'(DEF_PERIOD);
            presc_r     <= '0;
            presc_act_q <= '0;
            pre_cnt_q   <= '0;
            wait_q      <= '0;
            ovr_q       <= 1'b0;
            z_q         <= 1'b0;
            busy_q      <= 1'b0;
            p_q         <= 1'b0;
            p_qq        <= 1'b0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            period_r    <= period_d;
            presc_r     <= presc_d;
            presc_act_q <= presc_act_d;
            pre_cnt_q   <= pre_cnt_d;
            wait_q      <= wait_d;
            ovr_q       <= ovr_d;
            z_q         <= (state_d == S_EXPIRED);
            busy_q      <= (state_d == S_COUNT);
            p_q         <= bus.P;
            p_qq        <= p_q;
            step_q      <= step_d;
        end
    end

    assign bus.Z        = z_q;
    assign bus.busy     = busy_q;
    assign bus.count    = count_q;
    assign bus.step_cnt = step_q;
    assign bus.ovr      = ovr_q;
endmodule

// File: tb/tb_step_interval_timer.sv
// Directed bench for step_interval_timer; a second, narrow-step-counter
// instance exercises step counter saturation in few cycles.
module tb_step_interval_timer;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    step_interval_timer_if b ();
    step_interval_timer_if #(.STEP_W(4)) bs ();

    step_interval_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    step_interval_timer #(.STEP_W(4)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [15:0] per, input logic [7:0] pre);
        b.period_ld = 1'b1;
        b.period_in = per;
        b.presc_in  = pre;
        step(1);
        b.period_ld = 1'b0;
    endtask

    task automatic pulse_t();
        b.T = 1'b1;
        step(1);
        b.T = 1'b0;
    endtask

    task automatic pulse_p_small(input int n);
        repeat (n) begin
            bs.P = 1'b1;
            step(1);
            bs.P = 1'b0;
            step(1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        b.T = 1'b0; b.P = 1'b0; b.en = 1'b1; b.period_ld = 1'b0;
        b.period_in = '0; b.presc_in = '0;
        bs.T = 1'b0; bs.P = 1'b0; bs.en = 1'b0; bs.period_ld = 1'b0;
        bs.period_in = '0; bs.presc_in = '0;
        step(3);
        check("rst_z", 32'(b.Z), 32'd0);
        check("rst_busy", 32'(b.busy), 32'd0);
        check("rst_count", 32'(b.count), 32'd1000);
        check("rst_ovr", 32'(b.ovr), 32'd0);
        check("rst_step", 32'(b.step_cnt), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Basic count: period 5, prescale 0
        load(16'd5, 8'd0);
        check("ld_no_count_change", 32'(b.count), 32'd1000);
        pulse_t();
        check("basic_busy", 32'(b.busy), 32'd1);
        check("basic_count_ld", 32'(b.count), 32'd5);
        step(4);
        check("basic_z_early", 32'(b.Z), 32'd0);
        check("basic_count_1", 32'(b.count), 32'd1);
        step(1);
        check("basic_z", 32'(b.Z), 32'd1);
        check("basic_count_0", 32'(b.count), 32'd0);
        check("basic_busy_off", 32'(b.busy), 32'd0);

        // Overrun after four unanswered cycles; T does not clear it
        step(3);
        check("ovr_early", 32'(b.ovr), 32'd0);
        step(1);
        check("ovr_set", 32'(b.ovr), 32'd1);
        step(5);
        check("ovr_sticky", 32'(b.ovr), 32'd1);
        pulse_t();
        check("ovr_after_t", 32'(b.ovr), 32'd1);
        check("ovr_t_busy", 32'(b.busy), 32'd1);
        check("ovr_t_z", 32'(b.Z), 32'd0);
        load(16'd3, 8'd2);
        check("ovr_cleared", 32'(b.ovr), 32'd0);
        check("presc_deferred", 32'(b.count), 32'd4);

        // Prescale: period 3, presc 2 -> Z at +9
        pulse_t();
        check("pre_count_ld", 32'(b.count), 32'd3);
        step(8);
        check("pre_z_early", 32'(b.Z), 32'd0);
        step(1);
        check("pre_z", 32'(b.Z), 32'd1);

        // Freeze for 4 cycles -> Z at +13
        pulse_t();
        step(2);
        b.en = 1'b0;
        step(4);
        check("frz_count", 32'(b.count), 32'd3);
        b.en = 1'b1;
        step(6);
        check("frz_z_early", 32'(b.Z), 32'd0);
        step(1);
        check("frz_z", 32'(b.Z), 32'd1);

        // Retrigger at +3 -> Z at +8
        load(16'd5, 8'd0);
        pulse_t();
        step(2);
        pulse_t();
        check("rtg_count", 32'(b.count), 32'd5);
        step(4);
        check("rtg_z_early", 32'(b.Z), 32'd0);
        step(1);
        check("rtg_z", 32'(b.Z), 32'd1);

        // Bypass: period_ld with T uses period_in=2 -> Z at +2
        b.period_ld = 1'b1; b.period_in = 16'd2; b.presc_in = 8'd0; b.T = 1'b1;
        step(1);
        b.period_ld = 1'b0; b.T = 1'b0;
        check("byp_busy", 32'(b.busy), 32'd1);
        check("byp_count", 32'(b.count), 32'd2);
        check("byp_ovr", 32'(b.ovr), 32'd0);
        step(1);
        check("byp_z_early", 32'(b.Z), 32'd0);
        step(1);
        check("byp_z", 32'(b.Z), 32'd1);

        // T exactly when the overrun limit would be reached
        step(3);
        check("lim_pre", 32'(b.ovr), 32'd0);
        pulse_t();
        check("lim_t_wins", 32'(b.ovr), 32'd0);
        check("lim_busy", 32'(b.busy), 32'd1);
        step(2);
        check("lim_z", 32'(b.Z), 32'd1);
        step(4);
        check("lim_ovr_later", 32'(b.ovr), 32'd1);

        // Period 0: expired at the reload edge
        load(16'd0, 8'd0);
        check("p0_ovr_clr", 32'(b.ovr), 32'd0);
        pulse_t();
        check("p0_z", 32'(b.Z), 32'd1);
        check("p0_count", 32'(b.count), 32'd0);
        check("p0_busy", 32'(b.busy), 32'd0);
        step(4);
        check("p0_ovr", 32'(b.ovr), 32'd1);

        // Reset while expired with ovr set, then mid-count
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("rst2_ovr", 32'(b.ovr), 32'd0);
        check("rst2_z", 32'(b.Z), 32'd0);
        check("rst2_count", 32'(b.count), 32'd1000);
        b.en = 1'b0;
        pulse_t();
        check("t_while_frozen", 32'(b.busy), 32'd1);
        b.en = 1'b1;
        step(3);
        check("mid_count", 32'(b.count), 32'd997);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("rst3_z", 32'(b.Z), 32'd0);
        check("rst3_busy", 32'(b.busy), 32'd0);
        check("rst3_count", 32'(b.count), 32'd1000);
        check("rst3_ovr", 32'(b.ovr), 32'd0);

        // Step monitor: level held 3 cycles counts once, one edge late
        b.P = 1'b1;
        step(1);
        check("stp_latency", 32'(b.step_cnt), 32'd0);
        step(1);
        check("stp_one", 32'(b.step_cnt), 32'd1);
        step(1);
        check("stp_level", 32'(b.step_cnt), 32'd1);
        b.P = 1'b0;
        step(2);
        check("stp_hold", 32'(b.step_cnt), 32'd1);
        repeat (3) begin
            b.P = 1'b1;
            step(1);
            b.P = 1'b0;
            step(1);
        end
        check("stp_four", 32'(b.step_cnt), 32'd4);

        // Saturation on the narrow counter
        pulse_p_small(14);
        check("sat_14", 32'(bs.step_cnt), 32'd14);
        pulse_p_small(1);
        check("sat_max", 32'(bs.step_cnt), 32'd15);
        pulse_p_small(5);
        check("sat_hold", 32'(bs.step_cnt), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/step_interval_timer.md
# step_interval_timer

Interval timer that serves as the counterpart of the step-maker FSM. It consumes the step-maker's timer-restart request `T` and returns the expiry flag `Z`, counting a programmable prescaled period in between. It also monitors the step-maker's pace output `P`, counting issued steps and flagging an overrun when `Z` goes unanswered. It sits beside the step-maker in the pacing datapath, on the same clock.

## Interface
- `CNT_W`, 16, width of period and count
- `PRE_W`, 8, width of prescaler setting
- `DEF_PERIOD`, 1000, period loaded at reset
- `OVR_LIM`, 4, cycles `Z` may stay high without `T` before overrun
- `clk` in 1 — single clock; all logic on rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `T` in 1 — restart request; reload and start counting
- `P` in 1 — pace pulse from step-maker; monitored only
- `en` in 1 — count enable; 0 freezes prescaler and count
- `period_ld` in 1 — load `period_in`/`presc_in` into config registers
- `period_in` in `CNT_W` — new period, in prescaled ticks
- `presc_in` in `PRE_W` — new prescale; tick every `presc+1` cycles
- `Z` out 1 — expiry level; high in EXPIRED state
- `busy` out 1 — high in COUNT state
- `count` out `CNT_W` — current remaining ticks
- `step_cnt` out 16 — saturating count of `P` rising edges
- `ovr` out 1 — sticky overrun flag

## Operation
- Config registers `period_r` and `presc_r` are written on `period_ld`. A write takes effect at the next `T` reload and also clears `ovr`.
- State machine: IDLE, COUNT, EXPIRED. All outputs are registered.
  - **IDLE:** `T` → COUNT, loading `count = period_r` and clearing the prescaler. Otherwise stay.
  - **COUNT:** `T` → retrigger (reload, stay in COUNT). On a tick with `count == 1` → `count = 0`, next state EXPIRED. On other ticks, `count -= 1`.
  - **EXPIRED:** `T` → reload, go to COUNT. Otherwise the wait counter increments every cycle. When it reaches `OVR_LIM`, set `ovr = 1`; it stays 1 until reset or `period_ld`. State remains EXPIRED.
- Period 0 on reload: go directly to EXPIRED at the same edge, with `count = 0`.
- Prescaler: `pre_cnt` runs from 0 to `presc_r`. A tick occurs when `pre_cnt == presc_r` and `en = 1`. `pre_cnt` then wraps to 0. `presc_r = 0` gives a tick every enabled cycle.
- `en = 0` freezes `pre_cnt` and `count`. It never blocks `T`, and does not freeze the overrun wait counter.
- Priority: `rst_n` > `T` > tick/overrun logic.
- `period_ld` and `T` in the same cycle: the reload uses `period_in`/`presc_in` directly (bypass).
- `T` on the same cycle the overrun limit is reached: `T` wins and `ovr` is not set.
- Step monitor: `P` is registered, and a rising edge (`P & ~P_q`) increments `step_cnt`. `step_cnt` saturates at 16'hFFFF. The count updates one cycle after `P` rises.
- Reset (`rst_n` low at an edge, including mid-count) forces:
  - state IDLE, `Z = 0`, `busy = 0`, `ovr = 0`
  - `count = DEF_PERIOD`, `period_r = DEF_PERIOD`, `presc_r = 0`
  - `pre_cnt = 0`, wait counter = 0, `step_cnt = 0`, `P_q = 0`

## Timing
- `T` sampled high at edge k, with period N ≥ 1, prescale p, and `en` held high: `Z` rises at edge k + N·(p+1).
- `Z` and `busy` are decoded from registered state, with no combinational path from inputs.
- `Z` stays high until the edge sampling `T`. It falls at that edge, and `busy` rises at the same edge.
- `ovr` rises at the edge `OVR_LIM` cycles after `Z` rose, provided no `T` was sampled in that window.
- `step_cnt` changes one edge after the edge at which `P` is first sampled high.

## Test plan
- **Basic count:** reset; `period_ld` with period 5, presc 0; `T` pulse at edge 10 → `busy = 1` at 10, `Z = 1` at edge 15, `count` = 0.
- **Prescale and freeze:** period 3, presc 2, `T` at edge 0 → `Z` at edge 9. Repeat with `en = 0` for 4 cycles mid-count → `Z` at edge 13.
- **Retrigger and bypass:** period 5, `T` at 0, `T` again at 3 → `Z` at 8. Then `period_ld` with `period_in = 2` in the same cycle as `T` at edge 20 → `Z` at 22.
- **Overrun:** `Z` rises at edge 15, no `T`, `OVR_LIM = 4` → `ovr = 1` at edge 19, stays high. `T` at 25 leaves `ovr` high; `period_ld` at 30 clears it. `T` exactly at edge 19 → `ovr` stays 0.
- **Period 0 and reset mid-count:**
  - period 0, `T` at edge 5 → `Z = 1` at edge 5.
  - `rst_n` low at edge 12 during COUNT → `Z = 0`, `busy = 0`, `count = 1000`, `ovr = 0` at 12.
- **Step monitor:**
  - `P` high for 3 cycles → `step_cnt += 1` (edge-detected, not level).
  - Preset near the limit via 65536 pulses → `step_cnt` holds 16'hFFFF.
